fifo_sync_th: RTL and testbench
===============================

# fifo_sync_th

Parametrised single-clock FIFO with occupancy count, programmable almost-full/almost-empty thresholds, selectable read mode (registered or first-word-fall-through) and overflow/underflow error pulses. It replaces the fixed 4-entry push/pop buffer as the standard elastic buffer between producer and consumer stages that share `clk`. Storage is a register array addressed by wrap-around read/write pointers.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 4, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-1, almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1, almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- FWFT, 0, 0 = registered read, 1 = first-word-fall-through

Ports (AW = log2(DEPTH)):
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- push  in  1  write request
- din  in  WIDTH  write data, sampled on accepted push
- pop  in  1  read request
- dout  out  WIDTH  read data
- full  out  1  count == DEPTH
- pndng  out  1  count != 0 (data pending)
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  AW+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: push rejected
- underflow  out  1  one-cycle pulse: pop rejected

## Operation
- Pointers wr_ptr and rd_ptr are AW bits and wrap from DEPTH-1 to 0; count is a separate AW+1-bit register.
- pop_ok = pop & pndng. push_ok = push & (~full | pop_ok): pushing when full is accepted only with a simultaneous accepted pop.
- push_ok: mem[wr_ptr] ← din, wr_ptr +1. pop_ok: rd_ptr +1.
- count: +1 if push_ok & ~pop_ok; −1 if pop_ok & ~push_ok; unchanged otherwise.
- Push and pop both requested when empty: push accepted, pop rejected, underflow pulses.
- Push when full without pop: data dropped, no state change, overflow pulses. Pop when empty: no state change, underflow pulses.
- FWFT=0: on pop_ok, dout ← mem[rd_ptr] on the same edge; otherwise dout holds.
- FWFT=1: dout = mem[rd_ptr] combinationally; valid whenever pndng=1; undefined-but-stable content when pndng=0 is allowed; pop_ok advances to the next word.
- Flags are decoded from registered count; no flag depends combinationally on push/pop.

## Timing
- Reset values: count 0, pointers 0, pndng 0, full 0, almost_full 0, almost_empty 1, overflow 0, underflow 0, dout 0 (FWFT=0). Memory contents are not reset.
- rst dominates push/pop in the same cycle; mid-operation reset discards all contents.
- Write latency: push_ok at edge N → pndng/count/flags update after edge N; FWFT=1 dout valid from that point.
- Read latency FWFT=0: pop_ok at edge N → word visible on dout after edge N.
- overflow/underflow are registered: high for exactly the cycle after the offending edge.
- Full throughput: one push and one pop per cycle sustained at any occupancy 1..DEPTH.

## Structure
- Shared package fifo_pkg: pointer-width helper (log2), default WIDTH/DEPTH constants, read-mode constants FWFT_OFF=0 / FWFT_ON=1.
- Sub-module fifo_ram: DEPTH×WIDTH register array, one synchronous write port, one asynchronous read port. Top level holds pointers, count, flags and the read-mode output stage.

## Test plan
- Reset, then push 0x11,0x22,0x33,0x44 (DEPTH=4, FWFT=0) → count 1..4, full=1 after 4th, almost_full=1 from count 3; four pops → dout 0x11,0x22,0x33,0x44 one cycle after each pop, pndng=0 at end.
- Full FIFO, push 0x55 without pop → overflow pulse one cycle, count stays 4; subsequent reads never return 0x55.
- Full FIFO, push 0x66 with pop → count stays 4, full stays 1, 0x66 read last after wrap-around.
- Empty FIFO, push 0x77 with pop → underflow pulse, count 1; FWFT=1 variant: dout=0x77 the cycle pndng rises, with no pop needed.
- Continuous push+pop for 3×DEPTH cycles with incrementing data → count constant, output sequence in order across pointer wrap.
- Fill to 3, assert rst with push=1 → count 0, pndng 0, almost_empty 1, dout 0; next pop gives underflow.

Source files
------------

// File: rtl/fifo_sync_th_pkg.sv
// Shared constants and helpers for the synchronous threshold FIFO family.
package fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    localparam int FWFT_OFF  = 0;
    localparam int FWFT_ON   = 1;

    // Pointer width for a power-of-two depth (ceil(log2)).
    function automatic int ptr_w(input int depth);
        int w;
        w = 0;
        while ((1 << w) < depth) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_sync_th_if.sv
// Producer/consumer handshake bundle for fifo_sync_th.
interface fifo_sync_th_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
);
    localparam int AW = ptr_w(DEPTH);

    logic             push;
    logic [WIDTH-1:0] din;
    logic             pop;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             pndng;
    logic             almost_full;
    logic             almost_empty;
    logic [AW:0]      count;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, din, pop,
        input  dout, full, pndng, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  push, din, pop,
        output dout, full, pndng, almost_full, almost_empty, count, overflow, underflow
    );

endinterface

// File: rtl/fifo_sync_th_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_th.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// registered or first-word-fall-through read, and overflow/underflow pulses.
module fifo_sync_th
    import fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = FWFT_OFF
) (
    input  logic         clk,
    input  logic         rst,
    fifo_sync_th_if.slave bus
);

    localparam int AW = ptr_w(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             full, pndng;
    logic             push_ok, pop_ok;
    logic [WIDTH-1:0] rd_data;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign pndng   = (count_q != '0);
    assign pop_ok  = bus.pop & pndng;
    // A push into a full FIFO is only safe when the same edge frees a slot.
    assign push_ok = bus.push & (~full | pop_ok);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = bus.push & ~push_ok;
        underflow_d = bus.pop & ~pop_ok;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (push_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.din),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    generate
        if (FWFT == FWFT_ON) begin : g_fwft
            assign bus.dout = rd_data;
        end else begin : g_reg
            logic [WIDTH-1:0] dout_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (pop_ok) begin
                    dout_q <= rd_data;
                end
            end
            assign bus.dout = dout_q;
        end
    endgenerate

    assign bus.full         = full;
    assign bus.pndng        = pndng;
    assign bus.almost_full  = (count_q >= (AW+1)'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= (AW+1)'(AE_LEVEL));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_sync_th.sv
// Bench for fifo_sync_th: registered-read and FWFT instances driven in lockstep against a queue model.
module tb_fifo_sync_th;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_sync_th_if #(.WIDTH(8), .DEPTH(DEPTH)) bus0 ();
    fifo_sync_th_if #(.WIDTH(8), .DEPTH(DEPTH)) bus1 ();

    fifo_sync_th #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fifo_sync_th #(.WIDTH(8), .DEPTH(DEPTH), .FWFT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: plain queue of stored words plus the registered-read output word.
    int         mq[$];
    logic [7:0] m_d0  = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic [8:0] exp_st;

    logic [8:0] st0, st1;
    assign st0 = {bus0.count, bus0.full, bus0.pndng, bus0.almost_full, bus0.almost_empty, bus0.overflow, bus0.underflow};
    assign st1 = {bus1.count, bus1.full, bus1.pndng, bus1.almost_full, bus1.almost_empty, bus1.overflow, bus1.underflow};

    task automatic cycle(input logic p, input logic [7:0] d, input logic po, input logic r);
        bit pop_ok, push_ok;
        int sz;
        bus0.push = p; bus0.din = d; bus0.pop = po;
        bus1.push = p; bus1.din = d; bus1.pop = po;
        rst = r;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_d0 = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
        end else begin
            pop_ok  = po && (mq.size() > 0);
            push_ok = p && ((mq.size() < DEPTH) || pop_ok);
            if (pop_ok) m_d0 = 8'(mq.pop_front());
            if (push_ok) mq.push_back(int'(d));
            m_ovf = p && !push_ok;
            m_unf = po && !pop_ok;
        end
        #1;
        sz = mq.size();
        exp_st = {3'(sz), sz == DEPTH, sz != 0, sz >= DEPTH - 1, sz <= 1, m_ovf, m_unf};
    endtask

    task automatic test_reset();
        cycle(0, 8'h00, 0, 1);
        cycle(0, 8'h00, 0, 1);
        n_chk++;
        if (st0 !== 9'b000_0001_00) $display("FAIL reset_status act=%b req=%b", st0, 9'b000_0001_00);
        else n_pass++;
        n_chk++;
        if (bus0.dout !== 8'h00) $display("FAIL reset_dout act=%h req=00", bus0.dout);
        else n_pass++;
        n_chk++;
        if (st1 !== exp_st) $display("FAIL reset_status_fwft act=%b req=%b", st1, exp_st);
        else n_pass++;
    endtask

    task automatic test_fill_drain();
        logic [7:0] seq [4];
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            cycle(1, seq[i], 0, 0);
            n_chk++;
            if (st0 !== exp_st || int'(bus0.count) != i + 1 || bus0.almost_full !== (i >= 2) || bus0.full !== (i == 3))
                $display("FAIL fill_status[%0d] act=%b req=%b", i, st0, exp_st);
            else n_pass++;
            n_chk++;
            if (bus1.dout !== 8'h11) $display("FAIL fill_fwft_head[%0d] act=%h req=11", i, bus1.dout);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 8'h00, 1, 0);
            n_chk++;
            if (bus0.dout !== seq[i] || st0 !== exp_st)
                $display("FAIL drain[%0d] dout act=%h req=%h st act=%b req=%b", i, bus0.dout, seq[i], st0, exp_st);
            else n_pass++;
        end
        n_chk++;
        if (bus0.pndng !== 1'b0) $display("FAIL drain_pndng act=%b req=0", bus0.pndng);
        else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) cycle(1, 8'(8'hA0 + i), 0, 0);
        cycle(1, 8'h55, 0, 0);
        n_chk++;
        if (bus0.overflow !== 1'b1 || bus0.count !== 3'd4 || st0 !== exp_st)
            $display("FAIL overflow_pulse act=%b req=%b", st0, exp_st);
        else n_pass++;
        cycle(0, 8'h00, 0, 0);
        n_chk++;
        if (bus0.overflow !== 1'b0 || bus1.overflow !== 1'b0) $display("FAIL overflow_clear act=%b req=0", bus0.overflow);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 8'h00, 1, 0);
            n_chk++;
            if (bus0.dout === 8'h55 || bus0.dout !== 8'(8'hA0 + i))
                $display("FAIL overflow_drain[%0d] act=%h req=%h", i, bus0.dout, 8'(8'hA0 + i));
            else n_pass++;
        end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 4; i++) cycle(1, 8'(8'hB0 + i), 0, 0);
        cycle(1, 8'h66, 1, 0);
        n_chk++;
        if (bus0.count !== 3'd4 || bus0.full !== 1'b1 || bus0.dout !== 8'hB0 || bus0.overflow !== 1'b0)
            $display("FAIL full_push_pop act=%b/%h req=%b/b0", st0, bus0.dout, exp_st);
        else n_pass++;
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0);
        n_chk++;
        if (bus0.dout !== 8'h66 || bus0.pndng !== 1'b0) $display("FAIL full_wrap_last act=%h req=66", bus0.dout);
        else n_pass++;
    endtask

    task automatic test_empty_push_pop();
        cycle(1, 8'h77, 1, 0);
        n_chk++;
        if (bus0.underflow !== 1'b1 || bus0.count !== 3'd1 || st0 !== exp_st)
            $display("FAIL empty_push_pop act=%b req=%b", st0, exp_st);
        else n_pass++;
        n_chk++;
        if (bus1.pndng !== 1'b1 || bus1.dout !== 8'h77) $display("FAIL fwft_first_word act=%h req=77", bus1.dout);
        else n_pass++;
        cycle(0, 8'h00, 1, 0);
        n_chk++;
        if (bus0.dout !== 8'h77 || bus0.underflow !== 1'b0) $display("FAIL empty_push_pop_read act=%h req=77", bus0.dout);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int errs = 0;
        cycle(1, 8'h00, 0, 0);
        cycle(1, 8'h01, 0, 0);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            cycle(1, 8'(i + 2), 1, 0);
            if (bus0.count !== 3'd2 || bus0.dout !== 8'(i) || bus1.dout !== 8'(i + 1) || st0 !== exp_st) errs++;
        end
        n_chk++;
        if (errs != 0) $display("FAIL back_to_back act=%0d bad cycles req=0", errs);
        else n_pass++;
        cycle(0, 8'h00, 1, 0);
        cycle(0, 8'h00, 1, 0);
    endtask

    task automatic test_rst_mid();
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'hC0 + i), 0, 0);
        cycle(0, 8'h00, 1, 0);
        cycle(1, 8'hEE, 0, 1);
        n_chk++;
        if (st0 !== 9'b000_0001_00 || bus0.dout !== 8'h00)
            $display("FAIL rst_mid act=%b/%h req=%b/00", st0, bus0.dout, 9'b000_0001_00);
        else n_pass++;
        cycle(0, 8'h00, 1, 0);
        n_chk++;
        if (bus0.underflow !== 1'b1 || bus1.underflow !== 1'b1 || bus0.count !== 3'd0)
            $display("FAIL rst_mid_underflow act=%b req=1", bus0.underflow);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        logic p, po, r;
        for (int i = 0; i < 400; i++) begin
            p  = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            r  = ($urandom_range(0, 99) < 2);
            cycle(p, 8'($urandom), po, r);
            if (st0 !== exp_st || st1 !== exp_st || bus0.dout !== m_d0) errs++;
            if (mq.size() > 0 && bus1.dout !== 8'(mq[0])) errs++;
        end
        n_chk++;
        if (errs != 0) $display("FAIL random act=%0d bad cycles req=0", errs);
        else n_pass++;
    endtask

    initial begin
        bus0.push = 0; bus0.pop = 0; bus0.din = 0;
        bus1.push = 0; bus1.pop = 0; bus1.din = 0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_back_to_back();
        test_rst_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
